// File: rtl/snes_decoder.sv
// SNES controller poller: periodically latches the pad, clocks out 16 serial
// bits, and publishes the decoded (active-high) button word with a valid pulse.
//
// Frame timeline (cycles counted from the first latch-high cycle):
//   LATCH    LATCH_CYCLES cycles, pad_latch=1
//   GAP      HALF_CYCLES cycles, bit 0 sampled on the last one
//   16 x     CLK_LOW (HALF_CYCLES) + CLK_HIGH (HALF_CYCLES)
//            bit k is sampled on the last cycle of high phase k (k = 1..15)
//   DONE     1 cycle, buttons/valid update
// The 16th high phase is HALF_CYCLES-1 cycles long. DONE also drives pad_clk
// high, so the controller still sees a full-width high phase. This keeps the
// busy window equal to the frame length
// LATCH_CYCLES + HALF_CYCLES + 32*HALF_CYCLES.
// The poll timer is reloaded with POLL_CYCLES-1 on the frame-start edge. The
// next frame therefore starts POLL_CYCLES cycles later, and never earlier than
// one IDLE cycle after DONE.
module snes_decoder #(
    parameter int LATCH_CYCLES = 12,
    parameter int HALF_CYCLES  = 6,
    parameter int POLL_CYCLES  = 16667
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        pad_data,
    output logic        pad_clk,
    output logic        pad_latch,
    output logic [15:0] buttons,
    output logic        valid,
    output logic        busy
);

    localparam int TW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    localparam logic [15:0]   LATCH_END  = 16'(LATCH_CYCLES - 1);
    localparam logic [15:0]   HALF_END   = 16'(HALF_CYCLES - 1);
    localparam logic [15:0]   LAST_END   = 16'(HALF_CYCLES - 2);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LATCH    = 3'd1,
        GAP      = 3'd2,
        CLK_LOW  = 3'd3,
        CLK_HIGH = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t        state;
    logic          sync1;
    logic          sync2;
    logic [15:0]   shreg;
    logic [15:0]   cnt;
    logic [3:0]    pulse;
    logic [TW-1:0] timer;
    logic          start;

    // A frame begins when polling is enabled and the poll interval has elapsed.
    assign start = (state == IDLE) && enable && (timer == '0);

    // Two-flop synchronizer for the asynchronous pad data line (idles high).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= pad_data;
            sync2 <= sync1;
        end
    end

    // Poll timer: reload on frame start, otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (start) begin
            timer <= TIMER_LOAD;
        end else if (timer != '0) begin
            timer <= timer - 1'b1;
        end
    end

    // Frame sequencer. Outputs are assigned with the next state, so they are
    // registered and aligned with the state they belong to.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pulse     <= '0;
            shreg     <= '0;
            buttons   <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            pad_clk   <= 1'b1;
            pad_latch <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        state     <= LATCH;
                        pad_latch <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                LATCH: begin
                    if (cnt == LATCH_END) begin
                        state     <= GAP;
                        cnt       <= '0;
                        pad_latch <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == HALF_END) begin
                        shreg   <= {sync2, shreg[15:1]};
                        state   <= CLK_LOW;
                        cnt     <= '0;
                        pulse   <= '0;
                        pad_clk <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CLK_LOW: begin
                    if (cnt == HALF_END) begin
                        state   <= CLK_HIGH;
                        cnt     <= '0;
                        pad_clk <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CLK_HIGH: begin
                    if (pulse == 4'd15) begin
                        // Final high phase: no sample; DONE completes it.
                        if (cnt == LAST_END) begin
                            state   <= DONE;
                            cnt     <= '0;
                            buttons <= ~shreg;
                            valid   <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (cnt == HALF_END) begin
                        shreg   <= {sync2, shreg[15:1]};
                        state   <= CLK_LOW;
                        cnt     <= '0;
                        pulse   <= pulse + 1'b1;
                        pad_clk <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    valid     <= 1'b0;
                    busy      <= 1'b0;
                    pad_clk   <= 1'b1;
                    pad_latch <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snes_decoder.sv
// Directed bench for snes_decoder: default-parameter instance driven by a
// shift-register controller model, plus a POLL_CYCLES=210 instance for
// back-to-back framing.
module tb_snes_decoder;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        pad_data;
    logic        pad_clk;
    logic        pad_latch;
    logic [15:0] buttons;
    logic        valid;
    logic        busy;

    logic        reset_n_f;
    logic        enable_f;
    logic        pad_data_f;
    logic        pad_clk_f;
    logic        pad_latch_f;
    logic [15:0] buttons_f;
    logic        valid_f;
    logic        busy_f;

    int n_cmp;
    int n_bad;

    logic [15:0] pattern;
    logic [15:0] ctl_sh;
    logic        ctl_prev_clk;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    snes_decoder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .pad_data  (pad_data),
        .pad_clk   (pad_clk),
        .pad_latch (pad_latch),
        .buttons   (buttons),
        .valid     (valid),
        .busy      (busy)
    );

    snes_decoder #(.POLL_CYCLES(210)) dut_fast (
        .clk       (clk),
        .reset_n   (reset_n_f),
        .enable    (enable_f),
        .pad_data  (pad_data_f),
        .pad_clk   (pad_clk_f),
        .pad_latch (pad_latch_f),
        .buttons   (buttons_f),
        .valid     (valid_f),
        .busy      (busy_f)
    );

    // Controller model: parallel load while latched, shift on pad_clk rise,
    // released (1) bits fill in behind. Driven away from the active edge.
    initial begin
        ctl_sh       = 16'hFFFF;
        ctl_prev_clk = 1'b1;
        pad_data     = 1'b1;
    end
    always @(negedge clk) begin
        if (pad_latch) begin
            ctl_sh = pattern;
        end else if (pad_clk && !ctl_prev_clk) begin
            ctl_sh = {1'b1, ctl_sh[15:1]};
        end
        ctl_prev_clk = pad_clk;
        pad_data     = ctl_sh[0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hold reset for a few cycles; returns on a negedge with reset released.
    task automatic do_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Enable and wait for the frame's valid pulse; flags a timeout.
    task automatic run_frame(input string tag);
        int waited;
        enable = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!valid && waited < 400);
        check({tag, "_valid_seen"}, 32'(valid), 32'd1);
    endtask

    logic [15:0] pat_tab [3] = '{16'hF0F5, 16'h1234, 16'h0000};
    logic [15:0] exp_tab [3] = '{16'h0F0A, 16'hEDCB, 16'hFFFF};

    initial begin
        int latch_cnt, latch_first, latch_last, low_cnt, fall_cnt;
        int valid_cnt, valid_at, busy_cnt, rise_cnt, rise1, rise2;
        int valid_bad, idle_gap, done_at;
        logic prev_c, prev_l;

        n_cmp      = 0;
        n_bad      = 0;
        pattern    = 16'hFFFF;
        reset_n_f  = 1'b0;
        enable_f   = 1'b0;
        pad_data_f = 1'b1;

        // reset state
        do_reset();
        check("rst_pad_clk",   32'(pad_clk),   32'd1);
        check("rst_pad_latch", 32'(pad_latch), 32'd0);
        check("rst_buttons",   32'(buttons),   32'd0);
        check("rst_valid",     32'(valid),     32'd0);
        check("rst_busy",      32'(busy),      32'd0);

        // one frame with nothing pressed: waveform timing
        enable = 1'b1;
        latch_cnt = 0; latch_first = 0; latch_last = 0; low_cnt = 0;
        fall_cnt = 0; valid_cnt = 0; valid_at = 0; busy_cnt = 0;
        prev_c = 1'b1;
        for (int c = 1; c <= 230; c++) begin
            @(negedge clk);
            if (pad_latch) begin
                latch_cnt++;
                if (latch_first == 0) latch_first = c;
                latch_last = c;
            end
            if (!pad_clk) low_cnt++;
            if (!pad_clk && prev_c) fall_cnt++;
            prev_c = pad_clk;
            if (valid) begin
                valid_cnt++;
                valid_at = c;
            end
            if (busy) busy_cnt++;
        end
        check("f1_latch_first", 32'(latch_first), 32'd1);
        check("f1_latch_last",  32'(latch_last),  32'd12);
        check("f1_latch_cnt",   32'(latch_cnt),   32'd12);
        check("f1_low_pulses",  32'(fall_cnt),    32'd16);
        check("f1_low_cycles",  32'(low_cnt),     32'd96);
        check("f1_valid_cnt",   32'(valid_cnt),   32'd1);
        check("f1_valid_at",    32'(valid_at),    32'd210);
        check("f1_busy_cnt",    32'(busy_cnt),    32'd210);
        check("f1_buttons",     32'(buttons),     32'h0000);

        // decoded button patterns
        for (int i = 0; i < 3; i++) begin
            pattern = pat_tab[i];
            do_reset();
            run_frame($sformatf("pat%0d", i));
            check($sformatf("pat%0d_buttons", i), 32'(buttons), 32'(exp_tab[i]));
        end

        // free run: latch period, hold between frames, reset during pulse 8
        pattern = 16'hF0F5;
        do_reset();
        enable = 1'b1;
        rise_cnt = 0; rise1 = 0; rise2 = 0; fall_cnt = 0; valid_bad = 0;
        prev_l = 1'b0;
        prev_c = 1'b1;
        for (int c = 1; c <= 17200; c++) begin
            @(negedge clk);
            if (pad_latch && !prev_l) begin
                rise_cnt++;
                if (rise_cnt == 1) rise1 = c;
                if (rise_cnt == 2) rise2 = c;
            end
            prev_l = pad_latch;
            if (rise_cnt == 2 && !pad_clk && prev_c) fall_cnt++;
            prev_c = pad_clk;
            if (fall_cnt == 8) break;
        end
        check("fr_rise1",        32'(rise1),         32'd1);
        check("fr_period",       32'(rise2 - rise1), 32'd16667);
        check("fr_hold_buttons", 32'(buttons),       32'h0F0A);
        reset_n = 1'b0;
        @(negedge clk);
        check("mr_pad_clk",   32'(pad_clk),   32'd1);
        check("mr_pad_latch", 32'(pad_latch), 32'd0);
        check("mr_buttons",   32'(buttons),   32'd0);
        check("mr_busy",      32'(busy),      32'd0);
        check("mr_valid",     32'(valid),     32'd0);
        reset_n = 1'b1;
        enable  = 1'b0;
        for (int c = 0; c < 250; c++) begin
            @(negedge clk);
            if (valid) valid_bad++;
        end
        check("mr_no_valid", 32'(valid_bad), 32'd0);

        // enable dropped mid-frame: frame completes, no new frame
        pattern = 16'h1234;
        do_reset();
        enable = 1'b1;
        rise_cnt = 0; valid_cnt = 0;
        prev_l = 1'b0;
        for (int c = 1; c <= 17200; c++) begin
            @(negedge clk);
            if (c == 100) enable = 1'b0;
            if (pad_latch && !prev_l) rise_cnt++;
            prev_l = pad_latch;
            if (valid) valid_cnt++;
        end
        check("en_valid_cnt", 32'(valid_cnt), 32'd1);
        check("en_latch_cnt", 32'(rise_cnt),  32'd1);
        check("en_buttons",   32'(buttons),   32'hEDCB);

        // POLL_CYCLES=210: one IDLE cycle between DONE and next LATCH
        reset_n_f = 1'b0;
        repeat (3) @(negedge clk);
        reset_n_f = 1'b1;
        enable_f  = 1'b1;
        done_at = 0; idle_gap = 0; rise_cnt = 0; rise1 = 0; rise2 = 0;
        prev_l = 1'b0;
        for (int c = 1; c <= 700; c++) begin
            @(negedge clk);
            if (valid_f && done_at == 0) done_at = c;
            if (done_at != 0 && rise1 == 0 && !busy_f) idle_gap++;
            if (pad_latch_f && !prev_l) begin
                rise_cnt++;
                if (rise_cnt == 2) rise1 = c;
                if (rise_cnt == 3) rise2 = c;
            end
            prev_l = pad_latch_f;
        end
        check("fast_done_at",    32'(done_at),         32'd210);
        check("fast_next_latch", 32'(rise1),           32'd212);
        check("fast_idle_gap",   32'(idle_gap),        32'd1);
        check("fast_period",     32'(rise2 - rise1),   32'd211);
        check("fast_buttons",    32'(buttons_f),       32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
